hls_run_sequencer: RTL

Command-driven controller that sequences one Bambu-generated `main` accelerator. It loads input bytes through the accelerator's slave memory port and resets it. It then pulses `start_port`, counts cycles until `done_port` and reads result bytes back. Host-side requests arrive on a valid/ready command channel, and each completed command returns one response on a valid/ready response channel. It sits between the host/test harness and the accelerator.

---
 rtl/hls_run_sequencer.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hls_run_sequencer.sv
// ----------------------------------------------------------------------------
// hls_run_sequencer
//
// Command-driven controller that sequences one Bambu-generated `main`
// accelerator. The host issues byte writes, byte reads and run requests on a
// valid/ready command channel. Every completed command produces exactly one
// response on a valid/ready response channel.
//
// Ports
//   clock, reset        : single rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake
//   cmd_op              : 0 write byte, 1 read byte, 2 run, 3 reserved
//   cmd_addr, cmd_wdata : slave byte address and write data
//   rsp_valid/rsp_ready : response handshake
//   rsp_data            : read data (0 for other ops)
//   rsp_cycles          : run length in cycles (0 for memory ops)
//   rsp_status          : 0 ok, 1 run timeout, 2 memory timeout, 3 illegal op
//   acc_reset_n         : accelerator reset, active-low
//   start_port          : accelerator start pulse
//   done_port           : accelerator done
//   S_* / Sout_*        : two-channel slave memory port; only channel 0 is used
// ----------------------------------------------------------------------------
module hls_run_sequencer #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SIZE_W      = 4,
    parameter int TIMEOUT     = 200000000,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [31:0]           rsp_cycles,
    output logic [1:0]            rsp_status,

    output logic                  acc_reset_n,
    output logic                  start_port,
    input  logic                  done_port,

    output logic [1:0]            S_oe_ram,
    output logic [1:0]            S_we_ram,
    output logic [2*ADDR_W-1:0]   S_addr_ram,
    output logic [2*DATA_W-1:0]   S_Wdata_ram,
    output logic [2*SIZE_W-1:0]   S_data_ram_size,
    input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [1:0]            Sout_DataRdy
);

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
        ACC_RST,
        START,
        RUN,
        RESP
    } state_t;

    localparam logic [1:0] OP_WRITE   = 2'd0;
    localparam logic [1:0] OP_READ    = 2'd1;
    localparam logic [1:0] OP_RUN     = 2'd2;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_RUN_TO  = 2'd1;
    localparam logic [1:0] ST_MEM_TO  = 2'd2;
    localparam logic [1:0] ST_ILLEGAL = 2'd3;

    localparam int                 WCNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0]  MEM_TO_C  = WCNT_W'(MEM_TIMEOUT);
    localparam logic [31:0]        RUN_TO_C  = 32'(TIMEOUT);
    localparam logic [SIZE_W-1:0]  BYTE_BITS = SIZE_W'(8);

    state_t              state_reg;
    logic [1:0]          op_reg;

    logic                cmd_ready_reg;
    logic                rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_data_reg;
    logic [31:0]         rsp_cycles_reg;
    logic [1:0]          rsp_status_reg;

    logic                acc_reset_n_reg;
    logic                start_reg;

    // Channel-0 slave request registers; they are only non-zero in MEM_REQ.
    logic                s_oe_reg;
    logic                s_we_reg;
    logic [ADDR_W-1:0]   s_addr_reg;
    logic [DATA_W-1:0]   s_wdata_reg;
    logic [SIZE_W-1:0]   s_size_reg;

    // Second ACC_RST cycle marker.
    logic                rst_phase_reg;
    // MEM_WAIT cycle number, 1-based.
    logic [WCNT_W-1:0]   wait_cnt_reg;
    // Run length counter; equals 1 during the start_port cycle.
    logic [31:0]         cycle_cnt_reg;
    // Set for the single cycle in which the accelerator is reset after a run
    // timeout; the timeout response follows in the next cycle.
    logic                to_pulse_reg;

    // Channel-1 return path is never consulted.
    logic [DATA_W:0]     unused_inputs;
    assign unused_inputs = {Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            op_reg          <= 2'd0;
            cmd_ready_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_cycles_reg  <= '0;
            rsp_status_reg  <= ST_OK;
            acc_reset_n_reg <= 1'b0;
            start_reg       <= 1'b0;
            s_oe_reg        <= 1'b0;
            s_we_reg        <= 1'b0;
            s_addr_reg      <= '0;
            s_wdata_reg     <= '0;
            s_size_reg      <= '0;
            rst_phase_reg   <= 1'b0;
            wait_cnt_reg    <= '0;
            cycle_cnt_reg   <= '0;
            to_pulse_reg    <= 1'b0;
        end else begin
            // Single-cycle strobes and the slave request fall back to idle
            // values unless a state below asserts them.
            acc_reset_n_reg <= 1'b1;
            start_reg       <= 1'b0;
            s_oe_reg        <= 1'b0;
            s_we_reg        <= 1'b0;
            s_addr_reg      <= '0;
            s_wdata_reg     <= '0;
            s_size_reg      <= '0;

            case (state_reg)
                IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (cmd_valid && cmd_ready_reg) begin
                        cmd_ready_reg  <= 1'b0;
                        op_reg         <= cmd_op;
                        rsp_data_reg   <= '0;
                        rsp_cycles_reg <= '0;
                        rsp_status_reg <= ST_OK;
                        case (cmd_op)
                            OP_WRITE, OP_READ: begin
                                s_we_reg    <= (cmd_op == OP_WRITE);
                                s_oe_reg    <= (cmd_op == OP_READ);
                                s_addr_reg  <= cmd_addr;
                                s_wdata_reg <= (cmd_op == OP_WRITE) ? cmd_wdata : '0;
                                s_size_reg  <= BYTE_BITS;
                                state_reg   <= MEM_REQ;
                            end
                            OP_RUN: begin
                                acc_reset_n_reg <= 1'b0;
                                rst_phase_reg   <= 1'b0;
                                state_reg       <= ACC_RST;
                            end
                            default: begin
                                rsp_status_reg <= ST_ILLEGAL;
                                rsp_valid_reg  <= 1'b1;
                                state_reg      <= RESP;
                            end
                        endcase
                    end
                end

                MEM_REQ: begin
                    wait_cnt_reg <= WCNT_W'(1);
                    state_reg    <= MEM_WAIT;
                end

                MEM_WAIT: begin
                    if (Sout_DataRdy[0]) begin
                        if (op_reg == OP_READ) begin
                            rsp_data_reg <= Sout_Rdata_ram[DATA_W-1:0];
                        end
                        rsp_status_reg <= ST_OK;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= RESP;
                    end else if (wait_cnt_reg == MEM_TO_C) begin
                        rsp_data_reg   <= '0;
                        rsp_status_reg <= ST_MEM_TO;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WCNT_W'(1);
                    end
                end

                ACC_RST: begin
                    if (!rst_phase_reg) begin
                        rst_phase_reg   <= 1'b1;
                        acc_reset_n_reg <= 1'b0;
                    end else begin
                        start_reg     <= 1'b1;
                        cycle_cnt_reg <= 32'd1;
                        state_reg     <= START;
                    end
                end

                START: begin
                    if (cycle_cnt_reg < RUN_TO_C) begin
                        cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
                    end
                    state_reg <= RUN;
                end

                RUN: begin
                    if (to_pulse_reg) begin
                        to_pulse_reg   <= 1'b0;
                        rsp_cycles_reg <= RUN_TO_C;
                        rsp_status_reg <= ST_RUN_TO;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= RESP;
                    end else if (done_port) begin
                        rsp_cycles_reg <= cycle_cnt_reg;
                        rsp_status_reg <= ST_OK;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= RESP;
                    end else if (cycle_cnt_reg >= RUN_TO_C) begin
                        // Counter holds at TIMEOUT; knock the accelerator back
                        // into reset before reporting.
                        acc_reset_n_reg <= 1'b0;
                        to_pulse_reg    <= 1'b1;
                    end else begin
                        cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign rsp_cycles  = rsp_cycles_reg;
    assign rsp_status  = rsp_status_reg;
    assign acc_reset_n = acc_reset_n_reg;
    assign start_port  = start_reg;

    // Slave port lanes: channel 0 carries the request registers, channel 1
    // is permanently idle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            if (gi == 0) begin : g_used
                assign S_oe_ram[gi]                           = s_oe_reg;
                assign S_we_ram[gi]                           = s_we_reg;
                assign S_addr_ram[gi*ADDR_W +: ADDR_W]        = s_addr_reg;
                assign S_Wdata_ram[gi*DATA_W +: DATA_W]       = s_wdata_reg;
                assign S_data_ram_size[gi*SIZE_W +: SIZE_W]   = s_size_reg;
            end else begin : g_tied
                assign S_oe_ram[gi]                           = 1'b0;
                assign S_we_ram[gi]                           = 1'b0;
                assign S_addr_ram[gi*ADDR_W +: ADDR_W]        = '0;
                assign S_Wdata_ram[gi*DATA_W +: DATA_W]       = '0;
                assign S_data_ram_size[gi*SIZE_W +: SIZE_W]   = '0;
            end
        end
    endgenerate

endmodule
